ps2_frame_rx_fifo: RTL and testbench

- Parametrised successor to the single-frame PS/2 controller.
- Deserialises start/data/parity/stop frames from the serial line `D`, sampling only on `en` strobes.
- Checks parity and the stop bit, and buffers good frames in a show-ahead FIFO with a pop handshake.
- Sits between the PS/2 line conditioner (or the test shift register) and the keycode decoder.

---
 rtl/ps2_frame_rx_fifo.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_frame_rx_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx_fifo.sv
// PS/2 frame receiver: deserialises start/data/parity/stop frames sampled on en strobes into a show-ahead FIFO.
// Latency: a good frame is visible on Q/rdy/count 1 CLK after its stop-bit strobe; error pulses likewise 1 CLK later.
// Backpressure: none toward the line; a good frame arriving while the FIFO is full (and not popped) is dropped with ovf.
//
// Ports:
//   CLK, reset           - clock, asynchronous active-high reset
//   en, D                - bit-sample strobe and serial data line
//   rd                   - pop request (ignored while rdy=0)
//   Q, rdy, count        - FIFO head (0 when empty), non-empty flag, occupancy
//   par_err, frame_err   - one-cycle pulses for a dropped bad-parity / bad-stop (or stalled) frame
//   ovf                  - one-cycle pulse for a good frame dropped because the FIFO was full
// Optional build macro: PS2_TIMEOUT_EN adds a watchdog that aborts a frame after TIMEOUT_CYC cycles without en.

module ps2_frame_rx_fifo #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int PARITY_ODD  = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                              CLK,
    input  logic                              reset,
    input  logic                              en,
    input  logic                              D,
    input  logic                              rd,
    output logic [DATA_W-1:0]                 Q,
    output logic                              rdy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              par_err,
    output logic                              frame_err,
    output logic                              ovf
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic             PAR_SEL  = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_bit_q, par_bit_d;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic par_err_q, par_err_d;
    logic frame_err_q, frame_err_d;
    logic ovf_q, ovf_d;

    logic stop_smp;
    logic par_ok;
    logic push;
    logic pop;
    logic full;
    logic wr_en;
    logic timeout;

    // ------------------------------------------------------------------
    // Stall watchdog
    // ------------------------------------------------------------------
`ifdef PS2_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_q, wd_d;

    // wd_q counts idle cycles since the last strobe; the edge that would
    // make it reach TIMEOUT_CYC is the abort edge.
    always_comb begin
        wd_d    = wd_q;
        timeout = 1'b0;
        if (state_q == S_IDLE || en) begin
            wd_d = '0;
        end else if (wd_q == WD_LAST) begin
            timeout = 1'b1;
            wd_d    = '0;
        end else begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Frame deserialiser
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_bit_d = par_bit_q;
        stop_smp  = 1'b0;
        if (timeout) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
        end else if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (!D) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    // LSB arrives first: shift right so it ends at bit 0.
                    shreg_d   = {D, shreg_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_bit_d = D;
                    state_d   = S_STOP;
                end
                S_STOP: begin
                    stop_smp = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame evaluation and FIFO control
    // ------------------------------------------------------------------
    always_comb begin
        par_ok = (((^shreg_q) ^ par_bit_q) == PAR_SEL);
        push   = stop_smp && D && par_ok;
        pop    = rd && (count_q != '0);
        full   = (count_q == CNT_FULL);
        // When full, a simultaneous pop frees the head slot, which is
        // exactly where wr_ptr points, so the push can proceed.
        wr_en  = push && (!full || pop);

        par_err_d   = stop_smp && !par_ok;
        frame_err_d = (stop_smp && !D) || timeout;
        ovf_d       = push && full && !pop;

        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            par_bit_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_bit_q   <= par_bit_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage needs no reset: Q is masked to 0 whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    assign rdy       = (count_q != '0);
    assign Q         = rdy ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign par_err   = par_err_q;
    assign frame_err = frame_err_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ps2_frame_rx_fifo.sv
`timescale 1ns/1ps

module tb_ps2_frame_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int ODD   = 1;
`ifdef PS2_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          D = 1'b1;
    logic          rd = 1'b0;
    logic [DW-1:0] Q;
    logic          rdy;
    logic [2:0]    count;
    logic          par_err;
    logic          frame_err;
    logic          ovf;

    ps2_frame_rx_fifo #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .PARITY_ODD (ODD),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .en       (en),
        .D        (D),
        .rd       (rd),
        .Q        (Q),
        .rdy      (rdy),
        .count    (count),
        .par_err  (par_err),
        .frame_err(frame_err),
        .ovf      (ovf)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: contents of the FIFO as a plain queue of frames.
    int         model[$];
    int         exp_data[$];   // values that must be on Q when a pop is presented
    logic [2:0] exp_pulse[$];  // {par_err, frame_err, ovf}
    int         exp_pcyc[$];   // cycle in which that pulse must be seen
    int         snap_cnt = 0;  // model occupancy before the upcoming edge
    int         snap_head = 0;
    int         rd_pct = 0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on DUT events.
    always @(negedge CLK) begin
        if (reset) begin
            chk("rst_count", int'(count), 0);
            chk("rst_rdy", int'(rdy), 0);
            chk("rst_q", int'(Q), 0);
            chk("rst_pulse", int'({par_err, frame_err, ovf}), 0);
        end else begin
            chk("count", int'(count), snap_cnt);
            chk("rdy", int'(rdy), int'(snap_cnt != 0));
            chk("head_q", int'(Q), snap_head);
            if (rd && rdy) begin
                if (exp_data.size() == 0) chk("pop_unexpected", 1, 0);
                else chk("pop_data", int'(Q), exp_data.pop_front());
            end
            if ({par_err, frame_err, ovf} != 3'b000) begin
                if (exp_pulse.size() == 0) begin
                    chk("pulse_unexpected", int'({par_err, frame_err, ovf}), 0);
                end else begin
                    chk("pulse_kind", int'({par_err, frame_err, ovf}), int'(exp_pulse.pop_front()));
                    chk("pulse_cycle", cyc, exp_pcyc.pop_front());
                end
            end
        end
    end

    function automatic logic rnd_rd();
        return ($urandom_range(0, 99) < rd_pct);
    endfunction

    // One clock of stimulus; also advances the reference model for the
    // edge that is about to happen.
    task automatic step(input logic e, input logic d, input logic r,
                        input bit is_stop, input bit good,
                        input logic [2:0] err, input int dat);
        bit pop;
        @(posedge CLK);
        #1;
        en = e;
        D  = d;
        rd = r;
        snap_cnt  = model.size();
        snap_head = (model.size() > 0) ? model[0] : 0;
        pop = r && (model.size() > 0);
        if (pop) exp_data.push_back(model.pop_front());
        if (is_stop) begin
            if (good) begin
                if (snap_cnt == DEPTH && !pop) begin
                    exp_pulse.push_back(3'b001);
                    exp_pcyc.push_back(cyc + 1);
                end else begin
                    model.push_back(dat);
                end
            end else begin
                exp_pulse.push_back(err);
                exp_pcyc.push_back(cyc + 1);
            end
        end
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, r, 1'b0, 1'b0, 3'b000, 0);
    endtask

    task automatic send_frame(input int data, input bit bad_par, input bit stop, input bit rd_stop);
        logic [DW-1:0] dv;
        logic          bits[11];
        bit            good;
        logic [2:0]    err;
        dv = data[DW-1:0];
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[i+1] = dv[i];
        bits[9]  = logic'(ODD) ^ (^dv) ^ bad_par;
        bits[10] = stop;
        good = stop && !bad_par;
        err  = {bad_par, !stop, 1'b0};
        for (int k = 0; k < 11; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++)
                step(1'b0, logic'($urandom_range(0, 1)), rnd_rd(), 1'b0, 1'b0, 3'b000, 0);
            step(1'b1, bits[k], (k == 10) ? rd_stop : rnd_rd(), k == 10, good, err, int'(dv));
        end
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        reset = 1'b1;
        en = 1'b0;
        rd = 1'b0;
        D  = 1'b1;
        model.delete();
        exp_data.delete();
        exp_pulse.delete();
        exp_pcyc.delete();
        snap_cnt  = 0;
        snap_head = 0;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        do_reset();
        idle(2, 1'b0);

        // Directed: good frame, pop it, then a pop on an empty FIFO.
        rd_pct = 0;
        send_frame(32'h1C, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b1);

        // Bad parity, bad stop, both bad.
        send_frame(32'h1C, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b0);
        send_frame(32'h1C, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        send_frame(32'h5A, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Overflow without pop, then drain.
        send_frame(32'h11, 1'b0, 1'b1, 1'b0);
        send_frame(32'h22, 1'b0, 1'b1, 1'b0);
        send_frame(32'h33, 1'b0, 1'b1, 1'b0);
        send_frame(32'h44, 1'b0, 1'b1, 1'b0);
        send_frame(32'h55, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(5, 1'b1);

        // Full FIFO with pop coinciding with the stop strobe.
        send_frame(32'h11, 1'b0, 1'b1, 1'b0);
        send_frame(32'h22, 1'b0, 1'b1, 1'b0);
        send_frame(32'h33, 1'b0, 1'b1, 1'b0);
        send_frame(32'h44, 1'b0, 1'b1, 1'b0);
        send_frame(32'h55, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b0);
        idle(5, 1'b1);

        // Reset in the middle of a frame with two frames buffered.
        send_frame(32'h12, 1'b0, 1'b1, 1'b0);
        send_frame(32'h34, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 0);
        do_reset();
        idle(1, 1'b0);
        send_frame(32'hA5, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);

`ifdef PS2_TIMEOUT_EN
        // Stall after three data bits: watchdog aborts the frame.
        begin
            int last_en;
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 0);
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 0);
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 0);
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 0);
            last_en = cyc + 1;
            exp_pulse.push_back(3'b010);
            exp_pcyc.push_back(last_en + TO);
            idle(TO + 4, 1'b0);
            send_frame(32'h3C, 1'b0, 1'b1, 1'b0);
            idle(2, 1'b0);
            idle(2, 1'b1);
        end
`endif

        // Randomised traffic with varying pop pressure and error mix.
        for (int blk = 0; blk < 5; blk++) begin
            rd_pct = $urandom_range(0, 50);
            for (int f = 0; f < 50; f++) begin
                int sel;
                sel = $urandom_range(0, 9);
                send_frame(int'($urandom_range(0, 255)), sel == 0 || sel == 2,
                           !(sel == 1 || sel == 2), rnd_rd());
                for (int g = $urandom_range(0, 3); g > 0; g--)
                    step(logic'($urandom_range(0, 1)), 1'b1, rnd_rd(), 1'b0, 1'b0, 3'b000, 0);
            end
        end

        rd_pct = 0;
        idle(3, 1'b0);
        idle(DEPTH + 2, 1'b1);
        idle(2, 1'b0);
        chk("leftover_pulses", exp_pulse.size(), 0);
        chk("leftover_pops", exp_data.size(), 0);
        chk("final_model_empty", model.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
